// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector.
// Watches a qualified serial bit stream for a runtime-loadable pattern of up
// to PAT_W bits. Produces a registered one-cycle match pulse and a saturating
// match count. Matches can be overlapping or non-overlapping.
module seq_detect_prog #(
    parameter int               PAT_W     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = 4'b1011,
    parameter int               RESET_LEN = 4,
    localparam int              LEN_W     = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp_bit,
    input  logic             inp_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             seq_seen,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(1);

    // Active configuration
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;

    // Received-bit history; hist[0] is the newest bit
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] cfg_len_clamped;
    logic             match;

    // Clamp the requested length into the legal range 1..PAT_W
    always_comb begin
        cfg_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_clamped = LEN_MIN;
        end else if (cfg_len > LEN_MAX) begin
            cfg_len_clamped = LEN_MAX;
        end
    end

    // Build a mask that selects only the low len_r bits of the history
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_r));
        end
    end

    // Updated history/fill and match decision for the bit arriving this edge.
    // A coincident cfg_load discards the bit, so it can never produce a match.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], inp_bit};
        fill_next = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
        match     = inp_valid && !cfg_load && (fill_next >= len_r) &&
                    (((hist_next ^ pat_r) & len_mask) == '0);
    end

    // Configuration registers, replaced wholesale on cfg_load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r <= RESET_PAT;
            len_r <= LEN_W'(RESET_LEN);
            ovl_r <= 1'b1;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len_clamped;
            ovl_r <= cfg_overlap;
        end
    end

    // History shift, fill tracking and the registered match pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist     <= '0;
            fill     <= '0;
            seq_seen <= 1'b0;
        end else if (cfg_load) begin
            hist     <= '0;
            fill     <= '0;
            seq_seen <= 1'b0;
        end else if (inp_valid) begin
            seq_seen <= match;
            if (match && !ovl_r) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= hist_next;
                fill <= fill_next;
            end
        end else begin
            seq_seen <= 1'b0;
        end
    end

    // Saturating match counter; a clear wins over a coincident increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (count_clr) begin
            match_count <= '0;
        end else if (match && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule
